// File: rtl/rtc_bus_sequencer_if.sv
// Command and chip-bus signal bundle for rtc_bus_sequencer.
// master = controller/pin side, slave = the sequencer itself.
interface rtc_bus_sequencer_if;
    logic       req;
    logic       wr_nrd;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;

    logic [7:0] AdressDatai;
    logic       ADo;
    logic       CSo;
    logic       RDo;
    logic       WRo;
    logic [7:0] AdressDatao;
    logic       ad_oe;

    modport master (
        output req, wr_nrd, addr, wdata, AdressDatai,
        input  busy, done, rdata, ADo, CSo, RDo, WRo, AdressDatao, ad_oe
    );

    modport slave (
        input  req, wr_nrd, addr, wdata, AdressDatai,
        output busy, done, rdata, ADo, CSo, RDo, WRo, AdressDatao, ad_oe
    );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// Multiplexed address/data RTC chip-bus cycle engine: address phase, data phase, done pulse.
// Optional CS-recovery GAP phase enabled by defining RTC_BUS_GAP_EN.
module rtc_bus_sequencer #(
    parameter int T_PHASE = 4
) (
    input  logic                clock,
    input  logic                reset,
    rtc_bus_sequencer_if.slave  bus,
    output logic [2:0]          state_dbg
);

    localparam int CW = $clog2(T_PHASE + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADR      = 3'd1,
        S_ADR_HOLD = 3'd2,
        S_DAT      = 3'd3,
        S_DAT_HOLD = 3'd4,
`ifdef RTC_BUS_GAP_EN
        S_GAP      = 3'd5,
`endif
        S_DONE     = 3'd6
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic          phase_end;
    logic          accept;
    logic          cnt_load;

    logic          wr_q;
    logic [7:0]    addr_q;
    logic [7:0]    wdata_q;
    logic          cmd_wr;
    logic [7:0]    cmd_addr;
    logic [7:0]    cmd_wdata;
    logic          rd_load;

    logic          ad_d, cs_d, rd_d, wr_d, oe_d, busy_d, done_d;
    logic [7:0]    ado_d;

    // Handshake: req is a one-sided strobe accepted only while busy is low (IDLE);
    // there is no back-pressure, so a req seen while busy (including DONE) is dropped.
    assign accept    = (state == S_IDLE) && bus.req;
    assign phase_end = (cnt == CW'(1));
    assign cnt_load  = (state_next != state) && (state_next != S_IDLE) &&
                       (state_next != S_DONE);
    assign rd_load   = (state == S_DAT) && phase_end && !wr_q;
    assign state_dbg = state;

    // Outputs are registered from the next state, so the command being accepted
    // this edge must be taken from the ports rather than the not-yet-loaded latches.
    assign cmd_wr    = accept ? bus.wr_nrd : wr_q;
    assign cmd_addr  = accept ? bus.addr   : addr_q;
    assign cmd_wdata = accept ? bus.wdata  : wdata_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (cnt_load)
                cnt <= CW'(T_PHASE);
            else if (cnt != '0)
                cnt <= cnt - CW'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (bus.req)   state_next = S_ADR;
            S_ADR:      if (phase_end) state_next = S_ADR_HOLD;
            S_ADR_HOLD: if (phase_end) state_next = S_DAT;
            S_DAT:      if (phase_end) state_next = S_DAT_HOLD;
`ifdef RTC_BUS_GAP_EN
            S_DAT_HOLD: if (phase_end) state_next = S_GAP;
            S_GAP:      if (phase_end) state_next = S_DONE;
`else
            S_DAT_HOLD: if (phase_end) state_next = S_DONE;
`endif
            S_DONE:     state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ad_d   = 1'b1;
        cs_d   = 1'b1;
        rd_d   = 1'b1;
        wr_d   = 1'b1;
        oe_d   = 1'b0;
        ado_d  = 8'h00;
        busy_d = (state_next != S_IDLE);
        done_d = (state_next == S_DONE);
        case (state_next)
            S_ADR: begin
                ad_d  = 1'b0;
                cs_d  = 1'b0;
                wr_d  = 1'b0;
                oe_d  = 1'b1;
                ado_d = cmd_addr;
            end
            S_ADR_HOLD: begin
                oe_d  = 1'b1;
                ado_d = cmd_addr;
            end
            S_DAT: begin
                cs_d = 1'b0;
                if (cmd_wr) begin
                    wr_d  = 1'b0;
                    oe_d  = 1'b1;
                    ado_d = cmd_wdata;
                end else begin
                    rd_d  = 1'b0;
                end
            end
            S_DAT_HOLD: begin
                if (cmd_wr) begin
                    oe_d  = 1'b1;
                    ado_d = cmd_wdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q            <= 1'b0;
            addr_q          <= 8'h00;
            wdata_q         <= 8'h00;
            bus.ADo         <= 1'b1;
            bus.CSo         <= 1'b1;
            bus.RDo         <= 1'b1;
            bus.WRo         <= 1'b1;
            bus.ad_oe       <= 1'b0;
            bus.AdressDatao <= 8'h00;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.rdata       <= 8'h00;
        end else begin
            if (accept) begin
                wr_q    <= bus.wr_nrd;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
            end
            bus.ADo         <= ad_d;
            bus.CSo         <= cs_d;
            bus.RDo         <= rd_d;
            bus.WRo         <= wr_d;
            bus.ad_oe       <= oe_d;
            bus.AdressDatao <= ado_d;
            bus.busy        <= busy_d;
            bus.done        <= done_d;
            if (rd_load)
                bus.rdata <= bus.AdressDatai;
        end
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Self-checking bench for rtc_bus_sequencer: per-cycle bus scoreboard plus a T_PHASE=1 instance.
// Builds with or without RTC_BUS_GAP_EN.
module tb_rtc_bus_sequencer;

`ifdef RTC_BUS_GAP_EN
    localparam int TP = 2;
    localparam int NP = 5;
`else
    localparam int TP = 4;
    localparam int NP = 4;
`endif
    localparam int W = 31;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] state_dbg;
    logic [2:0] state_dbg1;
    int         cyc = 0;

    logic [W-1:0] exp_q[$];
    logic [7:0]   rd_q[$];
    logic [7:0]   exp_rdata = 8'h00;
    int           n_checks = 0;
    int           n_pass = 0;

    rtc_bus_sequencer_if bus();
    rtc_bus_sequencer_if bus1();

    rtc_bus_sequencer #(.T_PHASE(TP)) u_dut (
        .clock(clock), .reset(reset), .bus(bus.slave), .state_dbg(state_dbg)
    );

    rtc_bus_sequencer #(.T_PHASE(1)) u_dut1 (
        .clock(clock), .reset(reset), .bus(bus1.slave), .state_dbg(state_dbg1)
    );

    // clock / reset
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s act=%h exp=%h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Expected bus word for cycle i of a transaction:
    // {ADo,CSo,RDo,WRo, ad_oe, AdressDatao, busy, done}
    function automatic logic [14:0] exp_bus(input int i, input logic wr,
                                            input logic [7:0] a, input logic [7:0] d);
        logic [3:0] s;
        logic       oe;
        logic [7:0] dat;
        logic       dn;
        int         ph;
        s   = 4'b1111;
        oe  = 1'b0;
        dat = 8'h00;
        dn  = 1'b0;
        ph  = (i - 1) / TP;
        if (i == NP * TP + 1) begin
            dn = 1'b1;
        end else begin
            case (ph)
                0: begin s = 4'b0010; oe = 1'b1; dat = a; end
                1: begin oe = 1'b1; dat = a; end
                2: begin
                    if (wr) begin s = 4'b1010; oe = 1'b1; dat = d; end
                    else    s = 4'b1001;
                end
                3: if (wr) begin oe = 1'b1; dat = d; end
                default: ;
            endcase
        end
        return {s, oe, dat, 1'b1, dn};
    endfunction

    // driver: one transaction; optional stray req at cycle poke, held req from
    // cycle hold with (hw,ha,hd), or reset asserted at cycle abort_at
    task automatic run_txn(input logic wr, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] v, input int poke, input int hold,
                           input logic hw, input logic [7:0] ha, input logic [7:0] hd,
                           input int abort_at, input bit pre_held);
        int base;
        int n;
        int last;
        if (!pre_held) @(negedge clock);
        bus.wr_nrd      = wr;
        bus.addr        = a;
        bus.wdata       = d;
        bus.AdressDatai = 8'hEE;
        bus.req         = 1'b1;
        base = cyc;
        n    = NP * TP + 1;
        last = (abort_at > 0) ? abort_at - 1 : n;
        for (int i = 1; i <= last; i++)
            exp_q.push_back({16'(base + i), exp_bus(i, wr, a, d)});
        if (abort_at == 0) begin
            if (!wr) exp_rdata = v;
            rd_q.push_back(exp_rdata);
        end
        @(posedge clock); #1;
        bus.req = 1'b0;
        for (int c = 1; c <= n; c++) begin
            if (c == abort_at) begin
                reset = 1'b0;
                #1;
                check("abort_strobes", {28'h0, bus.ADo, bus.CSo, bus.RDo, bus.WRo}, 32'hF);
                check("abort_oe_busy_done", {29'h0, bus.ad_oe, bus.busy, bus.done}, 32'h0);
                check("abort_ado", {24'h0, bus.AdressDatao}, 32'h0);
                check("abort_rdata", {24'h0, bus.rdata}, {24'h0, exp_rdata});
                repeat (2) @(posedge clock);
                @(negedge clock);
                reset = 1'b1;
                exp_rdata = 8'h00;
                return;
            end
            bus.AdressDatai = (c > 2 * TP && c <= 3 * TP) ? v : 8'hEE;
            if (c == poke) begin
                bus.req = 1'b1; bus.wr_nrd = 1'b0; bus.addr = 8'h99; bus.wdata = 8'h99;
            end else if (hold > 0 && c >= hold) begin
                bus.req = 1'b1; bus.wr_nrd = hw; bus.addr = ha; bus.wdata = hd;
            end else begin
                bus.req = 1'b0;
            end
            @(posedge clock); #1;
        end
    endtask

    // monitor / scoreboard
    always @(negedge clock) begin
        if (reset && bus.busy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_busy", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                check("bus_cycle",
                      {1'b0, 16'(cyc), bus.ADo, bus.CSo, bus.RDo, bus.WRo, bus.ad_oe,
                       bus.AdressDatao, bus.busy, bus.done},
                      {1'b0, exp_q.pop_front()});
            end
            if (bus.done) begin
                if (rd_q.size() == 0) check("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
                else check("rdata_at_done", {24'h0, bus.rdata}, {24'h0, rd_q.pop_front()});
            end
        end
    end

    initial begin : main
        int b;
        int got;
        bus.req = 1'b0; bus.wr_nrd = 1'b0; bus.addr = 8'h00; bus.wdata = 8'h00;
        bus.AdressDatai = 8'h00;
        bus1.req = 1'b0; bus1.wr_nrd = 1'b0; bus1.addr = 8'h00; bus1.wdata = 8'h00;
        bus1.AdressDatai = 8'h00;

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_strobes", {28'h0, bus.ADo, bus.CSo, bus.RDo, bus.WRo}, 32'hF);
        check("rst_ado", {24'h0, bus.AdressDatao}, 32'h0);
        check("rst_oe_busy_done", {29'h0, bus.ad_oe, bus.busy, bus.done}, 32'h0);
        check("rst_rdata", {24'h0, bus.rdata}, 32'h0);
        check("rst_state", {29'h0, state_dbg}, 32'h0);

        // write 0x21 <- 0x45
        run_txn(1'b1, 8'h21, 8'h45, 8'hEE, 0, 0, 1'b0, 8'h00, 8'h00, 0, 1'b0);
        // read aborted by reset in the middle of DAT
        run_txn(1'b0, 8'h22, 8'h5A, 8'h5A, 0, 0, 1'b0, 8'h00, 8'h00, 2 * TP + 2, 1'b0);
        @(negedge clock);
        check("post_abort_rdata", {24'h0, bus.rdata}, 32'h0);
        check("post_abort_busy", {31'h0, bus.busy}, 32'h0);
        // read 0x22 -> 0x37
        run_txn(1'b0, 8'h22, 8'h00, 8'h37, 0, 0, 1'b0, 8'h00, 8'h00, 0, 1'b0);
        // write with a stray req (addr 0x99) at cycle 5
        run_txn(1'b1, 8'h30, 8'hA5, 8'hEE, 5, 0, 1'b0, 8'h00, 8'h00, 0, 1'b0);
        // read with the next request held from cycle 5 through DONE
        run_txn(1'b0, 8'h40, 8'h00, 8'hC3, 0, 5, 1'b1, 8'h55, 8'h66, 0, 1'b0);
        run_txn(1'b1, 8'h55, 8'h66, 8'hEE, 0, 0, 1'b0, 8'h00, 8'h00, 0, 1'b1);

        repeat (4) @(negedge clock);
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        check("rd_q_drained", 32'(rd_q.size()), 32'h0);
        check("final_rdata", {24'h0, bus.rdata}, 32'h0000_00C3);

        // T_PHASE=1 boundary: read, done NP+1 cycles after the req edge
        @(negedge clock);
        bus1.wr_nrd = 1'b0; bus1.addr = 8'h0F; bus1.AdressDatai = 8'h81; bus1.req = 1'b1;
        b = cyc;
        @(posedge clock); #1;
        bus1.req = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && got == 0; c++) begin
            @(negedge clock);
            if (bus1.done) got = cyc - b;
        end
        check("t1_done_latency", 32'(got), 32'(NP + 1));
        check("t1_rdata", {24'h0, bus1.rdata}, 32'h0000_0081);
        @(negedge clock);
        check("t1_idle_busy", {31'h0, bus1.busy}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
